// File: rtl/dmem_port_arbiter_if.sv
// DMEM port-A sharing bus: CPU pipeline side, external master side and
// the block-RAM port itself, bundled for the arbiter.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12
);
  // CPU (X stage)
  logic              cpu_en;
  logic [3:0]        cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_stall;
  logic [31:0]       cpu_rdata;

  // external master
  logic              ext_req;
  logic [3:0]        ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [31:0]       ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [31:0]       ext_rdata;

  // block-RAM port A
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_we;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  // arbiter side
  modport slave (
    input  cpu_en, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  ram_dout,
    output cpu_stall, cpu_rdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output ram_addr, ram_we, ram_din
  );

  // requester / RAM side
  modport master (
    output cpu_en, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output ram_dout,
    input  cpu_stall, cpu_rdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  ram_addr, ram_we, ram_din
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares DMEM port A between the CPU (default priority) and one external
// master. An external request denied MAX_WAIT consecutive cycles is forced
// through and stalls the CPU for that single cycle. Read data ownership is
// tracked across the 1-cycle RAM latency, and the last CPU load value is
// held so the CPU sees stable data through stall / ext-owned cycles.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int MAX_WAIT = 8
) (
  input logic                clk,
  input logic                rst,
  dmem_port_arbiter_if.slave bus
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        cpu_rd_q, cpu_rd_d;
  logic        ext_rd_q, ext_rd_d;
  logic [31:0] hold_q, hold_d;

  logic        force_grant;
  logic        ext_gnt;
  logic        cpu_stall;
  logic        cpu_acc;

  // Grant decision; everything that can touch the RAM is gated off in reset
  always_comb begin
    force_grant = bus.ext_req & (wait_cnt_q == MAX_WAIT_C);
    ext_gnt     = rst & bus.ext_req & (~bus.cpu_en | force_grant);
    cpu_stall   = rst & bus.cpu_en & force_grant;
    cpu_acc     = rst & bus.cpu_en & ~cpu_stall;
  end

  // Port-A mux: ext fields when granted, otherwise the CPU's (write only if enabled)
  always_comb begin
    bus.ram_addr = bus.cpu_addr;
    bus.ram_din  = bus.cpu_wdata;
    bus.ram_we   = 4'b0000;
    if (ext_gnt) begin
      bus.ram_addr = bus.ext_addr;
      bus.ram_din  = bus.ext_wdata;
      bus.ram_we   = bus.ext_we;
    end else if (cpu_acc) begin
      bus.ram_we   = bus.cpu_we;
    end
  end

  // Next-state: starvation counter, read ownership, CPU load hold register
  always_comb begin
    wait_cnt_d = 8'd0;
    if (bus.ext_req && !ext_gnt) begin
      wait_cnt_d = (wait_cnt_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 8'd1;
    end
    cpu_rd_d = cpu_acc & (bus.cpu_we == 4'b0000);
    ext_rd_d = ext_gnt & (bus.ext_we == 4'b0000);
    hold_d   = cpu_rd_q ? bus.ram_dout : hold_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_q <= 8'd0;
      cpu_rd_q   <= 1'b0;
      ext_rd_q   <= 1'b0;
      hold_q     <= 32'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      cpu_rd_q   <= cpu_rd_d;
      ext_rd_q   <= ext_rd_d;
      hold_q     <= hold_d;
    end
  end

  // Response routing: RAM data goes to whoever owned last cycle's read
  always_comb begin
    bus.cpu_stall  = cpu_stall;
    bus.ext_gnt    = ext_gnt;
    bus.ext_rvalid = ext_rd_q;
    bus.ext_rdata  = bus.ram_dout;
    bus.cpu_rdata  = cpu_rd_q ? bus.ram_dout : hold_q;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural RAM, directed scenarios and a
// randomized phase, all checked against a reference model kept here.
module tb_dmem_port_arbiter;

  localparam int ADDR_W   = 12;
  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Power-up RAM contents as a pure function of address
  function automatic logic [31:0] init_word(input logic [ADDR_W-1:0] a);
    case (a)
      12'h004: init_word = 32'h1234_5678;
      12'h008: init_word = 32'hCAFE_F00D;
      12'h010: init_word = 32'hDEAD_BEEF;
      12'h020: init_word = 32'h1122_3344;
      default: init_word = 32'h5A5A_0000 ^ ({20'h0, a} * 32'h9E37_79B1);
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [3:0] we,
                                              input logic [31:0] d);
    merge_bytes = old;
    for (int b = 0; b < 4; b++) if (we[b]) merge_bytes[8*b +: 8] = d[8*b +: 8];
  endfunction

  // Block RAM stand-in: synchronous read-first, byte write enables
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  bit          written [0:(1<<ADDR_W)-1];

  function automatic logic [31:0] ram_word(input logic [ADDR_W-1:0] a);
    ram_word = written[a] ? mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    bus.ram_dout <= ram_word(bus.ram_addr);
    if (bus.ram_we != 4'b0000) begin
      mem[bus.ram_addr]     <= merge_bytes(ram_word(bus.ram_addr), bus.ram_we, bus.ram_din);
      written[bus.ram_addr] <= 1'b1;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  bit          ref_wr  [0:(1<<ADDR_W)-1];
  int          streak  = 0;
  logic [31:0] exp_cpu = 32'd0;
  logic [31:0] exp_ext = 32'd0;
  bit          exp_rv  = 1'b0;
  bit          m_gnt   = 1'b0;
  bit          m_stall = 1'b0;

  function automatic logic [31:0] ref_read(input logic [ADDR_W-1:0] a);
    ref_read = ref_wr[a] ? ref_mem[a] : init_word(a);
  endfunction

  task automatic ref_write(input logic [ADDR_W-1:0] a, input logic [3:0] we, input logic [31:0] d);
    ref_mem[a] = merge_bytes(ref_read(a), we, d);
    ref_wr[a]  = 1'b1;
  endtask

  task automatic set_cpu(input bit en, input logic [3:0] we, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d);
    bus.cpu_en = en; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_ext(input bit req, input logic [3:0] we, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d);
    bus.ext_req = req; bus.ext_we = we; bus.ext_addr = a; bus.ext_wdata = d;
  endtask

  // One clock cycle: compare DUT with the model for the current inputs, then advance
  task automatic tick();
    bit                frc, gnt, stall, acc;
    logic [3:0]        we_e;
    logic [ADDR_W-1:0] a_e;
    logic [31:0]       d_e;
    #1;
    frc   = rst && bus.ext_req && (streak >= MAX_WAIT);
    gnt   = rst && bus.ext_req && (!bus.cpu_en || frc);
    stall = rst && bus.cpu_en && frc;
    acc   = rst && bus.cpu_en && !stall;
    we_e  = gnt ? bus.ext_we : (acc ? bus.cpu_we : 4'b0000);
    a_e   = gnt ? bus.ext_addr : bus.cpu_addr;
    d_e   = gnt ? bus.ext_wdata : bus.cpu_wdata;

    check_eq("ext_gnt",   32'(bus.ext_gnt),   32'(gnt));
    check_eq("cpu_stall", 32'(bus.cpu_stall), 32'(stall));
    check_eq("ram_we",    32'(bus.ram_we),    32'(we_e));
    check_eq("ram_addr",  32'(bus.ram_addr),  32'(a_e));
    if (we_e != 4'b0000) check_eq("ram_din", bus.ram_din, d_e);
    check_eq("cpu_rdata",  bus.cpu_rdata,       exp_cpu);
    check_eq("ext_rvalid", 32'(bus.ext_rvalid), 32'(exp_rv));
    if (exp_rv) check_eq("ext_rdata", bus.ext_rdata, exp_ext);

    m_gnt   = gnt;
    m_stall = stall;
    if (!rst) begin
      streak  = 0;
      exp_rv  = 1'b0;
      exp_cpu = 32'd0;
    end else begin
      if (gnt && bus.ext_we == 4'b0000) exp_ext = ref_read(bus.ext_addr);
      exp_rv = gnt && (bus.ext_we == 4'b0000);
      if (acc && bus.cpu_we == 4'b0000) exp_cpu = ref_read(bus.cpu_addr);
      if (we_e != 4'b0000) ref_write(a_e, we_e, d_e);
      if (bus.ext_req && !gnt) streak = (streak + 1 > MAX_WAIT) ? MAX_WAIT : streak + 1;
      else                     streak = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[$];
    int stalls[$];
    int first_gnt;
    bit pend;
    bit c_en;
    logic [3:0] c_we, e_we;
    logic [ADDR_W-1:0] c_addr, e_addr;
    logic [31:0] c_wd, e_wd;

    rst = 1'b0;
    set_cpu(1'b0, 4'b0, '0, 32'd0);
    set_ext(1'b0, 4'b0, '0, 32'd0);
    @(posedge clk);
    #1;

    // reset held with both sides requesting
    set_cpu(1'b1, 4'b1111, 12'h004, 32'hFFFF_FFFF);
    set_ext(1'b1, 4'b1111, 12'h008, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("rst_ram_we", 32'(bus.ram_we), 32'd0);
      check_eq("rst_gnt",    32'(bus.ext_gnt), 32'd0);
      tick();
    end
    rst = 1'b1;

    // CPU idle, ext read gets the port immediately
    set_cpu(1'b0, 4'b0, 12'h001, 32'd0);
    set_ext(1'b1, 4'b0000, 12'h010, 32'd0);
    #1;
    check_eq("idle_gnt", 32'(bus.ext_gnt), 32'd1);
    check_eq("idle_stall", 32'(bus.cpu_stall), 32'd0);
    tick();
    set_ext(1'b0, 4'b0, 12'h000, 32'd0);
    #1;
    check_eq("idle_rvalid", 32'(bus.ext_rvalid), 32'd1);
    check_eq("idle_rdata", bus.ext_rdata, 32'hDEAD_BEEF);
    tick();

    // starvation: continuous CPU loads, ext request never dropped
    set_ext(1'b1, 4'b0000, 12'h030, 32'd0);
    for (int c = 0; c < 18; c++) begin
      set_cpu(1'b1, 4'b0000, 12'(12'h100 + c), 32'd0);
      #1;
      if (bus.ext_gnt) grants.push_back(c);
      if (bus.cpu_stall) stalls.push_back(c);
      tick();
    end
    check_eq("starve_ngnt", 32'(grants.size()), 32'd2);
    check_eq("starve_nstall", 32'(stalls.size()), 32'd2);
    if (grants.size() == 2) begin
      check_eq("starve_gnt0", 32'(grants[0]), 32'd8);
      check_eq("starve_gnt1", 32'(grants[1]), 32'd17);
    end
    if (stalls.size() == 2) begin
      check_eq("starve_stall0", 32'(stalls[0]), 32'd8);
      check_eq("starve_stall1", 32'(stalls[1]), 32'd17);
    end
    set_ext(1'b0, 4'b0, 12'h000, 32'd0);
    set_cpu(1'b0, 4'b0, 12'h000, 32'd0);
    tick();

    // CPU load data held across a forced ext read
    set_ext(1'b1, 4'b0000, 12'h008, 32'd0);
    for (int c = 0; c < 7; c++) begin
      set_cpu(1'b1, 4'b0000, 12'(12'h200 + c), 32'd0);
      tick();
    end
    set_cpu(1'b1, 4'b0000, 12'h004, 32'd0);
    tick();
    #1;
    check_eq("hold_stall", 32'(bus.cpu_stall), 32'd1);
    check_eq("hold_gnt", 32'(bus.ext_gnt), 32'd1);
    check_eq("hold_n1", bus.cpu_rdata, 32'h1234_5678);
    tick();
    set_ext(1'b0, 4'b0, 12'h000, 32'd0);
    #1;
    check_eq("hold_n2", bus.cpu_rdata, 32'h1234_5678);
    check_eq("hold_rvalid", 32'(bus.ext_rvalid), 32'd1);
    check_eq("hold_rdata", bus.ext_rdata, 32'hCAFE_F00D);
    tick();

    // request withdrawal restarts the starvation count
    set_cpu(1'b1, 4'b0000, 12'h300, 32'd0);
    set_ext(1'b1, 4'b0000, 12'h040, 32'd0);
    for (int c = 0; c < 5; c++) tick();
    set_ext(1'b0, 4'b0000, 12'h040, 32'd0);
    tick();
    set_ext(1'b1, 4'b0000, 12'h040, 32'd0);
    first_gnt = -1;
    for (int c = 0; c < 20 && first_gnt < 0; c++) begin
      #1;
      if (bus.ext_gnt) first_gnt = c;
      tick();
    end
    check_eq("withdraw_gnt", 32'(first_gnt), 32'd8);
    set_ext(1'b0, 4'b0, 12'h000, 32'd0);
    set_cpu(1'b0, 4'b0, 12'h000, 32'd0);
    tick();

    // ext partial write, then CPU read-back of the merged word
    set_ext(1'b1, 4'b0011, 12'h020, 32'hAAAA_BBBB);
    #1;
    check_eq("wmask_we", 32'(bus.ram_we), 32'h3);
    tick();
    set_ext(1'b0, 4'b0, 12'h000, 32'd0);
    set_cpu(1'b1, 4'b0000, 12'h020, 32'd0);
    #1;
    check_eq("wmask_norv", 32'(bus.ext_rvalid), 32'd0);
    tick();
    set_cpu(1'b0, 4'b0, 12'h000, 32'd0);
    #1;
    check_eq("wmask_merge", bus.cpu_rdata, 32'h1122_BBBB);
    tick();

    // randomized traffic with occasional reset and withdrawals
    pend = 1'b0;
    c_en = 1'b0; c_we = '0; c_addr = '0; c_wd = '0;
    e_we = '0; e_addr = '0; e_wd = '0;
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      if (!m_stall) begin
        c_en   = ($urandom_range(0, 19) < ((i < 400) ? 14 : 19));
        c_we   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
        c_addr = 12'($urandom_range(0, 63));
        c_wd   = $urandom;
      end
      if (pend && $urandom_range(0, 19) == 0) begin
        pend = 1'b0;
      end else if (!pend && $urandom_range(0, 2) == 0) begin
        pend   = 1'b1;
        e_we   = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom);
        e_addr = 12'($urandom_range(0, 63));
        e_wd   = $urandom;
      end
      set_cpu(c_en, c_we, c_addr, c_wd);
      set_ext(pend, e_we, e_addr, e_wd);
      tick();
      if (m_gnt) pend = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single DMEM block-RAM port A between the CPU pipeline and one external master (bootloader/DMA/video fetch).
- The CPU has default priority. An external request that waits MAX_WAIT consecutive cycles is forced through, and the CPU is stalled for that one cycle.
- The block tracks ownership of the 1-cycle-latency RAM read data, routes it to the correct requester, and holds the CPU load data stable across stalls.

Parameters:
ADDR_W, 12, word-address width to RAM (byte address bits [13:2])
MAX_WAIT, 8, consecutive denied ext cycles before a forced grant (legal range 1..255)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (rst=0 resets on clk edge)
cpu_en  in  1  CPU issues a load or store this cycle (X stage)
cpu_we  in  4  CPU byte write mask; 0000 = load
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  32  CPU store data
cpu_stall  out  1  CPU access not performed this cycle; CPU holds and re-presents it
cpu_rdata  out  32  CPU load data, valid the cycle after its accepted load
ext_req  in  1  external access request; held with fields stable until ext_gnt
ext_we  in  4  external byte write mask; 0000 = read
ext_addr  in  ADDR_W  external word address
ext_wdata  in  32  external write data
ext_gnt  out  1  external access performed this cycle (combinational)
ext_rvalid  out  1  ext_rdata valid (cycle after a granted ext read)
ext_rdata  out  32  external read data
ram_addr  out  ADDR_W  to RAM addra
ram_we  out  4  to RAM wea
ram_din  out  32  to RAM dina
ram_dout  in  32  from RAM douta (synchronous, 1-cycle latency)

Behaviour:
- Registered state:
  - wait_cnt: 8-bit, saturates at MAX_WAIT.
  - cpu_rd_q: CPU load issued last cycle.
  - ext_rd_q: ext read granted last cycle.
  - hold_q: 32-bit last CPU load data.
- Reset (rst=0 at edge): wait_cnt=0, cpu_rd_q=0, ext_rd_q=0, hold_q=0.
- While rst=0, combinational outputs are forced: cpu_stall=0, ext_gnt=0, ram_we=0000.
- Outputs after reset: ext_rvalid=0, cpu_rdata=0.
- force = ext_req & (wait_cnt == MAX_WAIT).
- ext_gnt = ext_req & (~cpu_en | force).
- cpu_stall = cpu_en & force.
- CPU accepted = cpu_en & ~cpu_stall.
- RAM mux:
  - ext_gnt=1: drive ext_addr, ext_we, ext_wdata.
  - Else: drive cpu_addr and cpu_wdata; ram_we = cpu_we if cpu_en, else 0000.
- Idle cycle (neither side granted): ram_we=0000, ram_addr=cpu_addr.
- wait_cnt next value:
  - 0 if ~ext_req or ext_gnt.
  - Otherwise min(wait_cnt+1, MAX_WAIT).
- Dropping ext_req before a grant clears the count.
- cpu_rd_q next = CPU accepted & (cpu_we==0000).
- ext_rd_q next = ext_gnt & (ext_we==0000).
- ext_rvalid = ext_rd_q; ext_rdata = ram_dout. No response is returned for ext writes.
- cpu_rdata = cpu_rd_q ? ram_dout : hold_q.
- hold_q loads ram_dout whenever cpu_rd_q=1. CPU load data therefore stays stable through later stall or ext-owned cycles until the next CPU load returns.
- At most one port-A access per cycle. A stall lasts exactly one cycle per forced grant.
- After a forced grant wait_cnt=0, so the CPU gets at least MAX_WAIT cycles of priority before the next forced grant.
- Same-address conflict: ext write then CPU read of that address next cycle returns the new data (RAM ordering). No bypass in this block.
- MAX_WAIT=1: an ext request denied once is granted on the next cycle.
- Reset mid-access: pending rvalid/rdata ownership is discarded; no response after reset.

Test Plan:
- Reset: hold rst=0 for 3 cycles while cpu_en=1, ext_req=1 → ram_we=0000, cpu_stall=0, ext_gnt=0, ext_rvalid=0, cpu_rdata=0.
- CPU idle: cpu_en=0, ext_req=1 reading addr 0x010 (RAM holds 0xDEADBEEF) → ext_gnt=1 same cycle, ext_rvalid=1 with ext_rdata=0xDEADBEEF next cycle, cpu_stall never asserted.
- Starvation: cpu_en=1 continuous loads, ext_req=1, MAX_WAIT=8 → ext_gnt=0 for cycles 0..7, ext_gnt=1 and cpu_stall=1 on cycle 8, wait_cnt=0 after, next forced grant on cycle 17.
- Hold across stall: CPU load addr 0x004 (0x12345678) accepted cycle N, forced ext read 0x008 (0xCAFEF00D) cycle N+1 → cpu_rdata=0x12345678 on N+1 and N+2, ext_rdata=0xCAFEF00D with ext_rvalid on N+2.
- Request withdrawal: ext_req high 5 cycles under CPU load, low 1 cycle, high again → wait_cnt restarts at 0; forced grant only after 8 further denied cycles.
- Write masks: ext write ext_we=0011 data 0xAAAABBBB to addr 0x020 while cpu_en=0 → ram_we=0011 that cycle, no ext_rvalid; subsequent CPU load of 0x020 returns the lower half 0xBBBB merged with the prior upper half.
